// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB master that fronts the APB-to-I2C bridge.
package apb_i2c_pkg;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_TX  = 32'd0;
  localparam logic [ADDR_W-1:0] ADDR_RX  = 32'd4;
  localparam logic [ADDR_W-1:0] ADDR_CFG = 32'd8;
  localparam logic [ADDR_W-1:0] ADDR_TMO = 32'd12;

  // Command captured from the winning requester; drives PWRITE/PADDR/PWDATA.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_TX) || (addr == ADDR_RX) ||
           (addr == ADDR_CFG) || (addr == ADDR_TMO);
  endfunction

endpackage

// File: rtl/apb_i2c_master_arb_if.sv
// Requester-side handshake plus APB master bus of the arbitrating APB master.
interface apb_i2c_master_arb_if;
  import apb_i2c_pkg::*;

  logic [N_REQ-1:0]        REQ;
  logic [N_REQ-1:0]        WR;
  logic [N_REQ*ADDR_W-1:0] ADDR;
  logic [N_REQ*DATA_W-1:0] WDATA;
  logic [N_REQ-1:0]        ACK;
  logic [DATA_W-1:0]       RDATA;
  logic                    ERR;
  logic                    BUSY;

  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_W-1:0]       PADDR;
  logic [DATA_W-1:0]       PWDATA;
  logic [DATA_W-1:0]       PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  REQ, WR, ADDR, WDATA, PRDATA, PREADY, PSLVERR,
    output ACK, RDATA, ERR, BUSY, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output REQ, WR, ADDR, WDATA, PRDATA, PREADY, PSLVERR,
    input  ACK, RDATA, ERR, BUSY, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each grant strobe.
module apb_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_idx_c_o
);

  logic ptr_q, ptr_d;

  // Pointer holder wins ties; otherwise the only requester present wins.
  always_comb begin
    gnt_idx_c_o = ptr_q;
    if (!req_i[ptr_q]) begin
      gnt_idx_c_o = ~ptr_q;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = ~gnt_idx_c_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_i2c_master_arb.sv
// Round-robin two-requester APB master with bounded PREADY wait, feeding the I2C bridge.
module apb_i2c_master_arb
  import apb_i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_i2c_master_arb_if.master  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              gnt_q, gnt_d;
  apb_cmd_t          cmd_q, cmd_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;

  logic              gnt_idx_c;
  logic              grant_stb_c;
  apb_cmd_t          cmd_c;

  apb_rr_arb u_arb (
    .clk_i       (PCLK),
    .rst_i       (PRESET),
    .req_i       (bus.REQ),
    .upd_i       (grant_stb_c),
    .gnt_idx_c_o (gnt_idx_c)
  );

  // Select the winning requester's command fields.
  always_comb begin
    if (gnt_idx_c) begin
      cmd_c = '{wr:    bus.WR[1],
                addr:  bus.ADDR[ADDR_W +: ADDR_W],
                wdata: bus.WDATA[DATA_W +: DATA_W]};
    end else begin
      cmd_c = '{wr:    bus.WR[0],
                addr:  bus.ADDR[0 +: ADDR_W],
                wdata: bus.WDATA[0 +: DATA_W]};
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    gnt_d       = gnt_q;
    cmd_d       = cmd_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    grant_stb_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          grant_stb_c = 1'b1;
          gnt_d       = gnt_idx_c;
          cmd_d       = cmd_c;
          if (addr_legal(cmd_c.addr)) begin
            state_d = SETUP;
            tmo_d   = '0;
          end else begin
            // Illegal address completes without touching the bus.
            state_d          = DONE;
            ack_d[gnt_idx_c] = 1'b1;
            rdata_d          = '0;
            err_d            = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_d      = DONE;
          ack_d[gnt_q] = 1'b1;
          rdata_d      = cmd_q.wr ? '0 : bus.PRDATA;
          err_d        = bus.PSLVERR;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d      = DONE;
          ack_d[gnt_q] = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus strobes are registered copies of the decoded next state.
    busy_d    = (state_d != IDLE);
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      gnt_q     <= 1'b0;
      cmd_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
      cmd_q     <= cmd_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign bus.ACK     = ack_q;
  assign bus.RDATA   = rdata_q;
  assign bus.ERR     = err_q;
  assign bus.BUSY    = busy_q;
  assign bus.PSELx   = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = cmd_q.wr;
  assign bus.PADDR   = cmd_q.addr;
  assign bus.PWDATA  = cmd_q.wdata;

endmodule

// File: tb/tb_apb_i2c_master_arb.sv
// Directed self-checking bench for apb_i2c_master_arb with a hand-driven bridge.
module tb_apb_i2c_master_arb;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   acc_cycles;

  apb_i2c_master_arb_if bus ();

  apb_i2c_master_arb #(.TIMEOUT(16)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.REQ     = 2'b00;
    bus.WR      = 2'b00;
    bus.ADDR    = '0;
    bus.WDATA   = '0;
    bus.PRDATA  = '0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ack",     64'(bus.ACK),     64'h0);
    chk("rst_rdata",   64'(bus.RDATA),   64'h0);
    chk("rst_err",     64'(bus.ERR),     64'h0);
    chk("rst_busy",    64'(bus.BUSY),    64'h0);
    chk("rst_psel",    64'(bus.PSELx),   64'h0);
    chk("rst_penable", 64'(bus.PENABLE), 64'h0);
    chk("rst_pwrite",  64'(bus.PWRITE),  64'h0);
    chk("rst_paddr",   64'(bus.PADDR),   64'h0);
    chk("rst_pwdata",  64'(bus.PWDATA),  64'h0);

    // Single write from requester 0 to CONFIG
    bus.REQ    = 2'b01;
    bus.WR     = 2'b01;
    bus.ADDR   = {32'd0, 32'd8};
    bus.WDATA  = {32'd0, 32'h1234};
    bus.PREADY = 1'b1;
    tick();
    chk("wr_setup_psel",    64'(bus.PSELx),   64'h1);
    chk("wr_setup_penable", 64'(bus.PENABLE), 64'h0);
    chk("wr_setup_paddr",   64'(bus.PADDR),   64'h8);
    chk("wr_setup_pwdata",  64'(bus.PWDATA),  64'h1234);
    chk("wr_setup_pwrite",  64'(bus.PWRITE),  64'h1);
    chk("wr_setup_busy",    64'(bus.BUSY),    64'h1);
    chk("wr_setup_ack",     64'(bus.ACK),     64'h0);
    tick();
    chk("wr_access_psel",    64'(bus.PSELx),   64'h1);
    chk("wr_access_penable", 64'(bus.PENABLE), 64'h1);
    chk("wr_access_pwdata",  64'(bus.PWDATA),  64'h1234);
    tick();
    chk("wr_done_ack",  64'(bus.ACK),   64'h1);
    chk("wr_done_err",  64'(bus.ERR),   64'h0);
    chk("wr_done_psel", 64'(bus.PSELx), 64'h0);
    bus.REQ = 2'b00;
    tick();
    chk("wr_idle_ack",   64'(bus.ACK),   64'h0);
    chk("wr_idle_busy",  64'(bus.BUSY),  64'h0);
    chk("wr_idle_paddr", 64'(bus.PADDR), 64'h8);

    // Read from requester 1 at RX FIFO
    bus.REQ    = 2'b10;
    bus.WR     = 2'b00;
    bus.ADDR   = {32'd4, 32'd0};
    bus.PRDATA = 32'hA5A5_A5A5;
    tick();
    chk("rd_setup_paddr",  64'(bus.PADDR),  64'h4);
    chk("rd_setup_pwrite", 64'(bus.PWRITE), 64'h0);
    tick();
    tick();
    chk("rd_done_ack",   64'(bus.ACK),   64'h2);
    chk("rd_done_rdata", 64'(bus.RDATA), 64'hA5A5_A5A5);
    chk("rd_done_err",   64'(bus.ERR),   64'h0);
    bus.REQ = 2'b00;
    tick();

    // Both requesting: grants alternate 0,1,0,1
    bus.REQ   = 2'b11;
    bus.WR    = 2'b11;
    bus.ADDR  = {32'd0, 32'd0};
    bus.WDATA = {32'h22, 32'h11};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_pwdata", 64'(bus.PWDATA), (i % 2 == 0) ? 64'h11 : 64'h22);
      tick();
      tick();
      chk("rr_ack", 64'(bus.ACK), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i == 3) bus.REQ = 2'b00;
      tick();
    end

    // Illegal address: DONE after one edge, no APB activity
    bus.REQ  = 2'b01;
    bus.WR   = 2'b01;
    bus.ADDR = {32'd0, 32'd16};
    tick();
    chk("ill_ack",   64'(bus.ACK),   64'h1);
    chk("ill_err",   64'(bus.ERR),   64'h1);
    chk("ill_rdata", 64'(bus.RDATA), 64'h0);
    chk("ill_psel",  64'(bus.PSELx), 64'h0);
    bus.REQ = 2'b00;
    tick();
    chk("ill_idle_psel", 64'(bus.PSELx), 64'h0);
    chk("ill_idle_ack",  64'(bus.ACK),   64'h0);

    // PREADY held low: exactly 16 ACCESS cycles then timeout error
    bus.REQ    = 2'b10;
    bus.WR     = 2'b00;
    bus.ADDR   = {32'd12, 32'd0};
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFFFF_FFFF;
    tick();
    acc_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.PENABLE === 1'b1) acc_cycles++;
      if (bus.ACK !== 2'b00) break;
    end
    chk("tmo_access_cycles", 64'(acc_cycles), 64'd16);
    chk("tmo_ack",   64'(bus.ACK),   64'h2);
    chk("tmo_err",   64'(bus.ERR),   64'h1);
    chk("tmo_rdata", 64'(bus.RDATA), 64'h0);
    bus.REQ = 2'b00;
    tick();

    // Slave error on a completed write
    bus.REQ     = 2'b01;
    bus.WR      = 2'b01;
    bus.ADDR    = {32'd0, 32'd8};
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    tick();
    tick();
    tick();
    chk("slverr_ack",   64'(bus.ACK),   64'h1);
    chk("slverr_err",   64'(bus.ERR),   64'h1);
    chk("slverr_rdata", 64'(bus.RDATA), 64'h0);
    bus.REQ     = 2'b00;
    bus.PSLVERR = 1'b0;
    tick();

    // Reset during ACCESS aborts without ACK; pointer returns to requester 0
    bus.REQ    = 2'b01;
    bus.WDATA  = {32'hB1, 32'hA0};
    bus.PREADY = 1'b0;
    tick();
    tick();
    chk("prst_access_penable", 64'(bus.PENABLE), 64'h1);
    rst = 1'b1;
    tick();
    chk("prst_psel",    64'(bus.PSELx),   64'h0);
    chk("prst_penable", 64'(bus.PENABLE), 64'h0);
    chk("prst_ack",     64'(bus.ACK),     64'h0);
    chk("prst_busy",    64'(bus.BUSY),    64'h0);
    rst        = 1'b0;
    bus.REQ    = 2'b11;
    bus.WR     = 2'b11;
    bus.ADDR   = {32'd8, 32'd8};
    bus.PREADY = 1'b1;
    tick();
    chk("prst_next_pwdata", 64'(bus.PWDATA), 64'hA0);
    tick();
    tick();
    chk("prst_next_ack", 64'(bus.ACK), 64'h1);
    bus.REQ = 2'b00;
    tick();

    // Read with three wait states before PREADY
    bus.REQ    = 2'b10;
    bus.WR     = 2'b00;
    bus.ADDR   = {32'd4, 32'd0};
    bus.PRDATA = 32'hDEAD_BEEF;
    bus.PREADY = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("wait_penable", 64'(bus.PENABLE), 64'h1);
    chk("wait_ack",     64'(bus.ACK),     64'h0);
    bus.PREADY = 1'b1;
    tick();
    chk("wait_done_ack",   64'(bus.ACK),   64'h2);
    chk("wait_done_rdata", 64'(bus.RDATA), 64'hDEAD_BEEF);
    chk("wait_done_err",   64'(bus.ERR),   64'h0);
    bus.REQ = 2'b00;
    tick();
    chk("final_busy", 64'(bus.BUSY), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_i2c_master_arb.md
# apb_i2c_master_arb

Two-requester APB master that sequences all register traffic into the APB-to-I2C bridge slave. It arbitrates round-robin between requester 0 (CPU shim) and requester 1 (DMA/test sequencer). It drives correct SETUP/ACCESS phases, waits on PREADY with a bounded timeout, and returns read data and error status to the winning requester. It sits between the requesters and the bridge's APB slave port, on the same PCLK.

## Interface
- TIMEOUT, 16: max ACCESS cycles waiting for PREADY before abort (≥2).
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester request; held until ACK.
- WR  in  2  per-requester direction, 1 = write.
- ADDR  in  64  requester i address at ADDR[32*i +: 32].
- WDATA  in  64  requester i write data at WDATA[32*i +: 32].
- ACK  out  2  one-cycle completion pulse, one-hot or zero.
- RDATA  out  32  read data, valid with ACK.
- ERR  out  1  error status, valid with ACK.
- BUSY  out  1  high whenever state ≠ IDLE.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data from bridge.
- PREADY  in  1  bridge ready.
- PSLVERR  in  1  bridge error.

## Operation
- Legal addresses: 0 (TX FIFO write), 4 (RX FIFO read), 8 (CONFIG), 12 (TIMEOUT).
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE
  - Any REQ high: grant by round-robin pointer; latch WR/ADDR/WDATA of winner into PWRITE/PADDR/PWDATA.
  - Illegal ADDR: go to DONE with ERR=1 and RDATA=0; no APB activity.
  - Otherwise go to SETUP.
- SETUP: PSELx=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1.
  - PREADY=1: capture PRDATA (reads) or 0 (writes) into RDATA, capture PSLVERR into ERR, go to DONE.
  - PREADY=0 for TIMEOUT consecutive ACCESS cycles: ERR=1, RDATA=0, go to DONE.
- DONE: PSELx=PENABLE=0; ACK[grant]=1 for exactly one cycle; go to IDLE.
- Round-robin: pointer starts at 0 after reset. On each grant, the pointer moves to the other requester. With both REQ high, the pointer holder wins.
- Requesters must keep inputs stable from REQ high until the cycle after ACK. REQ sampled in DONE is ignored.
- TIMEOUT counter width is $clog2(TIMEOUT+1). It clears on SETUP entry.

## Timing
- Reset values: ACK=0, RDATA=0, ERR=0, BUSY=0, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; pointer=0; state IDLE.
- All outputs are registered.
- REQ high in IDLE at edge N:
  - SETUP visible in cycle N+1.
  - ACCESS visible in cycle N+2.
  - If PREADY is high in N+2, ACK is visible in N+3.
  - Next grant possible at edge N+4.
- Minimum 4 cycles per transfer. Illegal-address transfers take 2 cycles (IDLE→DONE).
- PADDR/PWDATA/PWRITE are stable from SETUP through ACCESS and hold their last value in IDLE/DONE.
- PRESET asserted in any state: IDLE at the next edge, with PSELx/PENABLE low. The aborted transfer produces no ACK.

## Structure
- Package apb_i2c_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - address constants ADDR_TX=0, ADDR_RX=4, ADDR_CFG=8, ADDR_TMO=12;
  - function addr_legal().
- Sub-module apb_rr_arb: 2-way round-robin arbiter with pointer register and grant-update strobe.

## Test plan
- Single write, REQ[0] ADDR=8 WDATA=0x1234, bridge PREADY=1 in ACCESS -> PWDATA=0x1234 in SETUP/ACCESS, ACK=01 at cycle N+3, ERR=0.
- Read, REQ[1] ADDR=4, PRDATA=0xA5A5A5A5 -> RDATA=0xA5A5A5A5 with ACK=10.
- Both REQ high after reset, ADDR=0 -> grant order 0,1,0,1; ACK alternates 01,10.
- Illegal ADDR=16 -> ACK at N+1, ERR=1, PSELx never high.
- PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then ACK with ERR=1, RDATA=0; PSLVERR=1 with PREADY=1 -> ERR=1.
- PRESET pulsed during ACCESS -> PSELx/PENABLE low next cycle, no ACK; next request is served by requester 0.
